// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame constants and the bit-period helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int FRAME_DATA_BITS = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic int uart_bit_period(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with push/pop, full/empty flags and an occupancy level.
// Depth is 2**FIFO_DEPTH_LOG2; pointers wrap naturally at that width.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [FRAME_DATA_BITS-1:0] wr_data,
    output logic [FRAME_DATA_BITS-1:0] rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [FIFO_DEPTH_LOG2:0]   level
);

    localparam int                   DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    logic [FRAME_DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic                       do_push;
    logic                       do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset so it can map onto RAM; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a registered-output serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_RATE       = 9600,
    parameter int CLOCK_FREQ_HZ   = 12000000,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FRAME_DATA_BITS-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam int BIT_PERIOD = uart_bit_period(CLOCK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDX_W      = $clog2(FRAME_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_DATA_BITS - 1);

    generate
        if (BIT_PERIOD < 2) begin : g_bad_bit_period
            $error("uart_tx_fifo: CLOCK_FREQ_HZ / BAUD_RATE must be at least 2");
        end
    endgenerate

    logic [2:0]                 state;
    logic [CNT_W-1:0]           bit_cnt;
    logic [IDX_W-1:0]           bit_idx;
    logic [FRAME_DATA_BITS-1:0] shift;
    logic [FRAME_DATA_BITS-1:0] head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       bit_last;
    logic                       push;
    logic                       pop;

    assign bit_last = (bit_cnt == CNT_LAST);
    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    // Popping at the end of STOP lets the next start bit follow with no idle gap.
    assign pop      = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_last));
    assign busy     = (state != S_IDLE) || (fifo_level != '0);

    uart_byte_fifo #(
        .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_data(in_data),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk) begin
        if (rst)      parity_bit <= 1'b0;
        else if (pop) parity_bit <= ^head;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            bit_cnt <= ((state == S_IDLE) || bit_last) ? '0 : bit_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_START;
                        shift <= head;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= parity_bit;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_last) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_last) begin
                        if (pop) begin
                            state <= S_START;
                            shift <= head;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (BIT_PERIOD = 4): frame table, directed corner cases
// and a randomized run against a queue-based reference model. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    localparam int BP    = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NSLOTS    = PAR ? 11 : 10;
    localparam int FRAME_CYC = NSLOTS * BP;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_level;

    uart_tx_fifo #(
        .BAUD_RATE      (2),
        .CLOCK_FREQ_HZ  (8),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending bytes, the byte on the line and cycles left in its frame.
    logic [7:0] mq[$];
    logic [7:0] cur_byte;
    int         frame_left = 0;

    // Stimulus drivers.
    logic [7:0] drv_q[$];
    int         hold_cycles = 0;
    logic [7:0] hold_data;
    bit         rand_mode = 1'b0;
    int         accepted = 0;
    int         busy_seen = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit i = i-th 8N1 line bit (start, d0..d7, stop)
        logic       par;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0)                 return 1'b0;
        if (slot <= 8)                 return b[slot-1];
        if (PAR && slot == 9)          return ^b;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        int lvl;
        if (r) begin
            mq.delete();
            frame_left = 0;
            return;
        end
        lvl = mq.size();
        if (frame_left <= 1) begin
            if (lvl != 0) begin
                cur_byte   = mq.pop_front();
                frame_left = FRAME_CYC;
            end else begin
                frame_left = 0;
            end
        end else begin
            frame_left--;
        end
        if (v && lvl < DEPTH) mq.push_back(d);
    endtask

    task automatic tick();
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       rdy;
        logic       exp_tx;
        if (rand_mode) begin
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
        end else if (hold_cycles > 0) begin
            in_valid = 1'b1;
            in_data  = hold_data;
        end else if (drv_q.size() != 0) begin
            in_valid = 1'b1;
            in_data  = drv_q[0];
        end else begin
            in_valid = 1'b0;
        end
        v = in_valid; d = in_data; r = rst; rdy = in_ready;
        @(posedge clk);
        model_edge(v, d, r);
        if (v && rdy) accepted++;
        if (!rand_mode) begin
            if (hold_cycles > 0) begin
                hold_cycles--;
                if (v && rdy) hold_data = hold_data + 8'd1;
            end else if (v && rdy) begin
                void'(drv_q.pop_front());
            end
        end
        #1;
        if (busy) busy_seen++;
        exp_tx = (frame_left == 0) ? 1'b1 : frame_bit(cur_byte, (FRAME_CYC - frame_left) / BP);
        check("model_tx", tx, exp_tx);
        check("model_level", fifo_level, mq.size());
        check("model_busy", busy, (frame_left != 0) || (mq.size() != 0));
        check("model_in_ready", in_ready, !rst && (mq.size() != DEPTH));
    endtask

    task automatic expect_frame(input vec_t v);
        logic exp;
        logic ok;
        for (int s = 0; s < NSLOTS; s++) begin
            if (s < 9)                exp = v.frame[s];
            else if (PAR && s == 9)   exp = v.par;
            else                      exp = v.frame[9];
            ok = 1'b1;
            for (int c = 0; c < BP; c++) begin
                tick();
                if (tx !== exp) ok = 1'b0;
            end
            check($sformatf("frame_%02h_slot%0d", v.data, s), ok, 1'b1);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{8'h31, 10'b1001100010, 1'b1};
        vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[2] = '{8'h03, 10'b1000000110, 1'b0};
        vecs[3] = '{8'h55, 10'b1010101010, 1'b0};
        vecs[4] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[5] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[6] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[7] = '{8'h80, 10'b1100000000, 1'b1};
        vecs[8] = '{8'h41, 10'b1010000010, 1'b0};
        vecs[9] = '{8'h42, 10'b1010000100, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        tick();
        tick();
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_level", fifo_level, 5'd0);
        check("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", in_ready, 1'b1);

        // Single frames from idle, one table entry at a time.
        for (int i = 0; i < 10; i++) begin
            drv_q.push_back(vecs[i].data);
            tick();
            check("tx_high_on_push_edge", tx, 1'b1);
            expect_frame(vecs[i]);
            tick();
            check("busy_after_frame", busy, 1'b0);
        end

        // Back-to-back frames: 0x41, 0x42, 0x43 with no idle gap.
        drv_q.push_back(8'h41);
        drv_q.push_back(8'h42);
        drv_q.push_back(8'h43);
        tick();
        busy_seen = 0;
        expect_frame(vecs[8]);
        expect_frame(vecs[9]);
        expect_frame('{8'h43, 10'b1010000110, 1'b1});
        check("busy_run_cycles", busy_seen, 3 * FRAME_CYC);
        tick();
        check("busy_after_chain", busy, 1'b0);

        // Hold in_valid for 20 cycles from idle: 16 stored plus the one already popped.
        accepted    = 0;
        hold_data   = 8'hB0;
        hold_cycles = 20;
        repeat (20) tick();
        check("hold_accepted", accepted, 17);
        check("hold_level_full", fifo_level, 5'd16);
        check("hold_in_ready_low", in_ready, 1'b0);
        wait_idle(17 * FRAME_CYC + 50);

        // Reset in the middle of the data bits of 0x55 with another byte queued.
        drv_q.push_back(8'h55);
        drv_q.push_back(8'h66);
        repeat (12) tick();
        rst = 1'b1;
        tick();
        check("midreset_tx", tx, 1'b1);
        check("midreset_level", fifo_level, 5'd0);
        check("midreset_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1'b1);
        begin
            logic quiet = 1'b1;
            repeat (3 * FRAME_CYC) begin
                tick();
                if (tx !== 1'b1) quiet = 1'b0;
            end
            check("no_frame_after_reset", quiet, 1'b1);
        end

        // Push on the last STOP cycle while one byte is queued: level holds, START follows.
        drv_q.push_back(8'h12);
        tick();
        repeat (4) tick();
        drv_q.push_back(8'h34);
        tick();
        repeat (FRAME_CYC - 5) tick();
        check("pre_stop_push_level", fifo_level, 5'd1);
        check("pre_stop_push_tx", tx, 1'b1);
        drv_q.push_back(8'h56);
        tick();
        check("stop_push_level", fifo_level, 5'd1);
        check("stop_push_start", tx, 1'b0);
        wait_idle(3 * FRAME_CYC + 10);

        // Randomized traffic against the reference model.
        rand_mode = 1'b1;
        repeat (3000) tick();
        rand_mode = 1'b0;
        wait_idle((DEPTH + 2) * FRAME_CYC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
